// File: rtl/i2s_rx_oversampled_if.sv
// i2s_rx_oversampled_if: valid/ready stream carrying one stereo frame.
//   tdata  : {left, right}, left in the MSBs, 2*SAMPLE_W bits
//   tvalid : frame valid (driven by the receiver)
//   tready : consumer ready (driven by the sink)
// Modports: master = receiver side, slave = consumer side.
interface i2s_rx_oversampled_if #(
   parameter int SAMPLE_W = 24
) ();
   logic [2*SAMPLE_W-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/i2s_rx_oversampled.sv
// i2s_rx_oversampled: Philips I2S slave receiver, oversampled in i_clk.
// SCK/WS/SD are synchronized, SCK rises become one-cycle strobes, and each
// left/right pair is presented on the m_axis stream with sticky overflow.
// Ports:
//   i_clk, i_rst_n      : oversampling clock (>= 6x SCK), async active-low reset
//   i_sck, i_ws, i_sd   : asynchronous I2S pins
//   m_axis (master)     : tdata {left, right}, tvalid, tready
//   o_overflow          : sticky, a frame was dropped; cleared by i_ovf_clr
//   o_locked            : aligned to frames
//   o_sck_lost          : sticky SCK watchdog flag (only with I2S_RX_TIMEOUT_EN)
// Optional feature macro: I2S_RX_TIMEOUT_EN enables the SCK watchdog;
// when undefined o_sck_lost is constant 0.
module i2s_rx_oversampled #(
   parameter int SAMPLE_W   = 24,
   parameter int SYNC_DEPTH = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_sck,
   input  logic                         i_ws,
   input  logic                         i_sd,
   i2s_rx_oversampled_if.master         m_axis,
   output logic                         o_overflow,
   input  logic                         i_ovf_clr,
   output logic                         o_locked,
   output logic                         o_sck_lost
);
   localparam int CW = $clog2(SAMPLE_W + 1);
   localparam int IW = $clog2(SAMPLE_W);
   localparam logic [CW-1:0] SW_C = CW'(SAMPLE_W);

   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

   logic [SYNC_DEPTH-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
   logic                  sck_dly_q;
   // Strobe and samples are registered together so WS/SD stay aligned with it.
   logic                  rise_q, ws_r_q, sd_r_q;

   state_t                state_q, state_d;
   logic [SAMPLE_W-1:0]   shift_q, shift_d, left_q, left_d, right_q, right_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  ws_prev_q, ws_prev_d;
   logic                  emit_q, emit_d;
   logic                  locked_q, locked_d;
   logic [2*SAMPLE_W-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  ovf_q, ovf_d;
   logic [SAMPLE_W-1:0]   word;
   logic [IW-1:0]         idx;

`ifdef I2S_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_C = TW'(TIMEOUT);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          lost_q, lost_d;
   logic          fire;
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      ws_prev_d = ws_prev_q;
      left_d    = left_q;
      right_d   = right_q;
      emit_d    = 1'b0;
      locked_d  = locked_q;
      word      = shift_q;
      idx       = IW'(SAMPLE_W - 1) - IW'(bit_cnt_q);

      if (rise_q) begin
         // Shift first: the LSB of the closing word arrives on the boundary edge.
         if (bit_cnt_q < SW_C) word[idx] = sd_r_q;
         ws_prev_d = ws_r_q;
         if (ws_r_q != ws_prev_q) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            case (state_q)
               SYNC:  if (!ws_r_q) begin state_d = LEFT; locked_d = 1'b1; end
               LEFT:  if (ws_r_q) begin left_d = word; state_d = RIGHT; end
               RIGHT: if (!ws_r_q) begin right_d = word; emit_d = 1'b1; state_d = LEFT; end
               default: state_d = SYNC;
            endcase
         end else begin
            shift_d = word;
            if (bit_cnt_q < SW_C) bit_cnt_d = bit_cnt_q + CW'(1);
         end
      end

      // Output stage: a new frame may replace an accepted one in the same cycle.
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      ovf_d    = ovf_q & ~i_ovf_clr;
      if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;
      if (emit_q) begin
         if (!tvalid_q || m_axis.tready) begin
            tdata_d  = {left_q, right_q};
            tvalid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

`ifdef I2S_RX_TIMEOUT_EN
      fire     = !rise_q && (to_cnt_q == TO_C - TW'(1));
      to_cnt_d = rise_q ? '0 : ((to_cnt_q == TO_C) ? to_cnt_q : to_cnt_q + TW'(1));
      lost_d   = fire | (lost_q & ~i_ovf_clr);
      if (fire) begin
         state_d   = SYNC;
         locked_d  = 1'b0;
         shift_d   = '0;
         bit_cnt_d = '0;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         sck_dly_q  <= 1'b0;
         rise_q     <= 1'b0;
         ws_r_q     <= 1'b0;
         sd_r_q     <= 1'b0;
         state_q    <= SYNC;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         ws_prev_q  <= 1'b0;
         left_q     <= '0;
         right_q    <= '0;
         emit_q     <= 1'b0;
         locked_q   <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_DEPTH-2:0], i_sck};
         ws_sync_q  <= {ws_sync_q[SYNC_DEPTH-2:0], i_ws};
         sd_sync_q  <= {sd_sync_q[SYNC_DEPTH-2:0], i_sd};
         sck_dly_q  <= sck_sync_q[SYNC_DEPTH-1];
         rise_q     <= sck_sync_q[SYNC_DEPTH-1] & ~sck_dly_q;
         ws_r_q     <= ws_sync_q[SYNC_DEPTH-1];
         sd_r_q     <= sd_sync_q[SYNC_DEPTH-1];
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         ws_prev_q  <= ws_prev_d;
         left_q     <= left_d;
         right_q    <= right_d;
         emit_q     <= emit_d;
         locked_q   <= locked_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef I2S_RX_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt_q <= '0;
         lost_q   <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         lost_q   <= lost_d;
      end
   end
   assign o_sck_lost = lost_q;
`else
   // Watchdog compiled out; the expression keeps TIMEOUT referenced.
   assign o_sck_lost = (TIMEOUT < 0);
`endif

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign o_overflow    = ovf_q;
   assign o_locked      = locked_q;
endmodule

// File: tb/tb_i2s_rx_oversampled.sv
module tb_i2s_rx_oversampled;
   localparam int SW = 24;
`ifdef I2S_RX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic sck = 1'b0, ws = 1'b0, sd = 1'b0, ovf_clr = 1'b0;
   logic ovf, locked, lost;
   int   half = 32;
   int   n_chk = 0, n_fail = 0;
   logic [2*SW-1:0] sb_q[$];

   i2s_rx_oversampled_if #(.SAMPLE_W(SW)) s_if ();

   i2s_rx_oversampled #(.SAMPLE_W(SW), .SYNC_DEPTH(2), .TIMEOUT(1024)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_ws(ws), .i_sd(sd),
      .m_axis(s_if.master), .o_overflow(ovf), .i_ovf_clr(ovf_clr),
      .o_locked(locked), .o_sck_lost(lost));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [SW-1:0] exp_word(input logic [31:0] d);
      return d[31 -: SW];
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_bit(input logic w, input logic d);
      sck = 1'b0; ws = w; sd = d;
      wait_clk(half);
      sck = 1'b1;
      wait_clk(half);
   endtask

   // Data is left-justified in d; the last bit of a slot carries the next WS.
   task automatic send_word(input logic [31:0] d, input int slot, input logic w);
      for (int i = 0; i < slot; i++)
         send_bit((i == slot - 1) ? ~w : w, d[31 - i]);
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                             input int slot, input bit push);
      if (push) sb_q.push_back({exp_word(l), exp_word(r)});
      send_word(l, slot, 1'b0);
      send_word(r, slot, 1'b1);
   endtask

   always @(negedge clk) begin
      if (rst_n && s_if.tvalid && s_if.tready) begin
         chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) chk("frame", 64'(s_if.tdata), 64'(sb_q.pop_front()));
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b;
      s_if.tready = 1'b1;
      wait_clk(4);
      chk("rst_tvalid", 64'(s_if.tvalid), 0);
      chk("rst_tdata", 64'(s_if.tdata), 0);
      chk("rst_ovf", 64'(ovf), 0);
      chk("rst_locked", 64'(locked), 0);
      chk("rst_lost", 64'(lost), 0);
      rst_n = 1'b1;
      wait_clk(2);

      // Basic: SCK = clk/64, 32-bit slots; first frame only acquires lock.
      send_frame(32'hDEADBEEF, 32'hCAFEF00D, 32, 1'b0);
      chk("basic_locked", 64'(locked), 1);
      send_frame(32'hA5A5A5C3, 32'h5A5A5A3C, 32, 1'b1);
      send_frame(32'h12345678, 32'h9ABCDEF0, 32, 1'b1);
      chk("basic_drained", 64'(sb_q.size()), 0);

      // Short and long slots at a faster SCK.
      half = 8;
      send_frame(32'hBEEF0000, 32'h12340000, 16, 1'b1);
      send_frame(32'h11223344, 32'h55667788, 32, 1'b1);
      for (int k = 0; k < 2; k++) begin
         a = $urandom; b = $urandom;
         send_frame(a, b, 32, 1'b1);
      end
      chk("slots_drained", 64'(sb_q.size()), 0);

      // Backpressure: second frame is dropped, first one held.
      s_if.tready = 1'b0;
      send_frame(32'hCAFE1200, 32'h0BAD3400, 32, 1'b1);
      chk("bp_valid", 64'(s_if.tvalid), 1);
      chk("bp_ovf0", 64'(ovf), 0);
      send_frame(32'h77777777, 32'h88888888, 32, 1'b0);
      chk("bp_hold", 64'(s_if.tdata), 64'({24'hCAFE12, 24'h0BAD34}));
      chk("bp_ovf1", 64'(ovf), 1);
      ovf_clr = 1'b1; wait_clk(1); ovf_clr = 1'b0; wait_clk(1);
      chk("bp_ovf_clr", 64'(ovf), 0);
      s_if.tready = 1'b1;
      wait_clk(3);
      chk("bp_accepted", 64'(s_if.tvalid), 0);
      chk("bp_drained", 64'(sb_q.size()), 0);

      // Lock acquisition: start mid right channel after reset.
      rst_n = 1'b0; wait_clk(2); rst_n = 1'b1; wait_clk(2);
      for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom));
      chk("acq_unlocked", 64'(locked), 0);
      send_bit(1'b0, 1'b1);
      chk("acq_locked", 64'(locked), 1);
      send_frame(32'h0F1E2D3C, 32'h4B5A6978, 32, 1'b1);
      chk("acq_drained", 64'(sb_q.size()), 0);

      // Reset in the middle of a left word.
      for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom));
      rst_n = 1'b0;
      wait_clk(3);
      chk("mid_rst_tvalid", 64'(s_if.tvalid), 0);
      chk("mid_rst_tdata", 64'(s_if.tdata), 0);
      chk("mid_rst_ovf", 64'(ovf), 0);
      chk("mid_rst_locked", 64'(locked), 0);
      rst_n = 1'b1;
      for (int i = 10; i < 32; i++) send_bit((i == 31) ? 1'b1 : 1'b0, 1'($urandom));
      send_word(32'hFFFFFFFF, 32, 1'b1);
      chk("mid_relock", 64'(locked), 1);
      send_frame(32'h13579BDF, 32'h2468ACE0, 32, 1'b1);
      chk("mid_drained", 64'(sb_q.size()), 0);

      // SCK stall of 1100 cycles.
      wait_clk(1100);
      chk("stall_lost", 64'(lost), 64'(TO_EN));
      chk("stall_locked", 64'(locked), 64'(!TO_EN));
      ovf_clr = 1'b1; wait_clk(1); ovf_clr = 1'b0; wait_clk(1);
      chk("stall_lost_clr", 64'(lost), 0);
      // With the watchdog the first frame only relocks; otherwise it is received.
      send_frame(32'hFEDCBA98, 32'h76543210, 32, !TO_EN);
      chk("stall_relock", 64'(locked), 1);
      send_frame(32'h0A0B0C0D, 32'hE0F01020, 32, 1'b1);

      wait_clk(20);
      chk("sb_drained", 64'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/i2s_rx_oversampled.md
Name: i2s_rx_oversampled

Overview:
- I2S slave receiver for the external audio/I2S device path, the receive end of the link whose master bit clock, MCLK and word select the clock block generates.
- Oversamples asynchronous SCK/WS/SD in a single fast clock domain and detects SCK edges.
- Deserializes standard Philips I2S stereo frames (WS low = left, MSB one SCK after the WS transition).
- Presents each complete left/right pair on a valid/ready stream with sticky overflow reporting.

Parameters:
- SAMPLE_W, 24, bits captured per channel (MSB-first); valid range 8..32.
- SYNC_DEPTH, 2, synchronizer flops on i_sck/i_ws/i_sd; minimum 2.
- TIMEOUT, 1024, i_clk cycles without an SCK rising edge before loss is declared (optional feature only).

Ports:
- i_clk  in  1  oversampling clock; must be at least 6x the SCK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sck  in  1  I2S bit clock (asynchronous).
- i_ws  in  1  I2S word select (asynchronous).
- i_sd  in  1  I2S serial data (asynchronous).
- o_tdata  out  2*SAMPLE_W  frame as {left, right}; left occupies the MSBs.
- o_tvalid  out  1  frame valid.
- i_tready  in  1  consumer ready.
- o_overflow  out  1  sticky flag: a frame was dropped.
- i_ovf_clr  in  1  single-cycle clear for o_overflow.
- o_locked  out  1  receiver is aligned to frames.
- o_sck_lost  out  1  sticky flag: SCK watchdog fired (optional feature; tied 0 when compiled out).

Behaviour:
- Reset values: all outputs 0; state SYNC; shift registers and bit counter 0.
- Synchronizers: i_sck, i_ws and i_sd each pass through SYNC_DEPTH flops, plus one extra flop on SCK for edge detection.
  - An SCK rising edge is sck_q && !sck_q_d (one-cycle strobe).
  - WS and SD take the same synchronizer depth, so at the strobe their sampled values are aligned with SCK.
- On each rise strobe:
  - Sample ws_s and sd_s.
  - boundary = (ws_s != ws_prev); then update ws_prev <= ws_s.
- Bit handling on each strobe, regardless of boundary:
  - If bit_cnt < SAMPLE_W: shift sd_s into the current word at position SAMPLE_W-1-bit_cnt and increment bit_cnt (saturating at SAMPLE_W).
  - Bits beyond SAMPLE_W are discarded.
  - A word shorter than SAMPLE_W is left-justified and zero-filled in its LSBs.
- On a boundary strobe, the current word closes and bit_cnt and the shift register clear. The close happens after the shift, because the I2S LSB arrives on the boundary edge.
- State machine:
  - SYNC: words are discarded. A boundary with ws_s=0 (falling WS) moves to LEFT and sets o_locked.
  - LEFT: on a boundary with ws_s=1, the closed word goes to the left register; move to RIGHT.
  - RIGHT: on a boundary with ws_s=0, the closed word goes to the right register, a frame is emitted, and the state moves to LEFT.
  - A boundary with an unexpected WS polarity cannot occur. WS is binary, so every boundary alternates.
- Frame emit (the cycle after the closing strobe):
  - If !o_tvalid or i_tready: load o_tdata = {left, right} and set o_tvalid.
  - Otherwise: drop the new frame, keep the old o_tdata and o_tvalid, and set o_overflow.
- Stream handshake:
  - o_tvalid clears on o_tvalid && i_tready, unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
  - o_tdata is stable while o_tvalid && !i_tready.
- o_overflow: cleared by i_ovf_clr. If a set and a clear occur in the same cycle, set wins.
- Latency: closing SCK rise at the pins to o_tvalid = SYNC_DEPTH + 3 i_clk cycles.
- Reset mid-frame: partial words are lost and the block returns to SYNC. The first frame after reset requires a full left word.

Optional Feature:
- Macro: I2S_RX_TIMEOUT_EN.
- Defined:
  - A counter clears on every rise strobe and increments otherwise, saturating.
  - On reaching TIMEOUT: state returns to SYNC, o_locked clears, partial words are discarded, and o_sck_lost is set (sticky).
  - o_sck_lost is cleared by i_ovf_clr.
  - o_tvalid and the pending frame are unaffected.
- Undefined: no counter; o_sck_lost is constant 0.

Test Plan:
- Basic: SAMPLE_W=24, SCK = i_clk/64, 32-bit slots; left=0xA5A5A5, right=0x5A5A5A -> one frame 0xA5A5A55A5A5A with o_tvalid, i_tready held 1; next frame matches the next pair.
- Lock acquisition: start streaming mid right-channel -> no output until WS falls; o_locked asserts on the first falling WS; the first frame carries the following left/right pair.
- Short/long slots: 16-bit slots with 0xBEEF/0x1234 -> tdata {0xBEEF00, 0x123400}; 32-bit slots with 0x11223344 -> left = 0x112233.
- Backpressure: i_tready=0 across two frames -> o_tdata holds the first frame, o_overflow=1; pulse i_ovf_clr -> 0; i_tready=1 -> the first frame is accepted.
- Reset mid-left-word: assert i_rst_n low for 3 cycles after 10 bits -> all outputs 0, o_locked=0; after release, relock on the next WS fall and receive a correct frame.
- Timeout (I2S_RX_TIMEOUT_EN, TIMEOUT=1024): stop SCK for 1100 cycles -> o_locked=0 and o_sck_lost=1 at cycle 1024; restart -> relock on the next WS fall.
